// File: rtl/mips32_prog_loader.sv
`default_nettype none
// ============================================================================
// mips32_prog_loader : streams a program into pipe_MIPS32 IMEM, then runs and
//                      watches the processor until HLT retires or time expires
// Revision 1.0
// ============================================================================
module mips32_prog_loader #(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned MAX_CYCLES = 4096,
  parameter logic [31:0] HLT_WORD   = 32'hfc000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_init,
  output logic              cpu_run,
  input  logic              cpu_halted,
  input  logic              start,
  output logic              done,
  output logic              error,
  output logic              timeout,
  output logic [ADDR_W:0]   word_count,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_INIT    = 3'd1,
    S_RUN     = 3'd2,
    S_DONE    = 3'd3,
    S_ERR     = 3'd4,
    S_TIMEOUT = 3'd5
  } state_e;

  localparam logic [ADDR_W-1:0] C_LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       C_WD_LIMIT = 32'(MAX_CYCLES - 1);

  state_e              state_q;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     word_count_q;
  logic [31:0]         cycle_count_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [31:0]         mem_wdata_q;
  logic                cpu_init_q;
  logic                cpu_run_q;
  logic                done_q;
  logic                error_q;
  logic                timeout_q;

  logic                w_accept;
  logic                w_end_beat;

  assign in_ready   = (state_q == S_LOAD);
  assign w_accept   = in_valid && in_ready;
  assign w_end_beat = in_last || (in_data == HLT_WORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_LOAD;
      ptr_q         <= '0;
      word_count_q  <= '0;
      cycle_count_q <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_init_q    <= 1'b0;
      cpu_run_q     <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      mem_we_q   <= 1'b0;
      cpu_init_q <= 1'b0;
      unique case (state_q)
        S_LOAD: begin
          if (w_accept) begin
            mem_we_q     <= 1'b1;
            mem_addr_q   <= ptr_q;
            mem_wdata_q  <= in_data;
            ptr_q        <= ptr_q + 1'b1;
            word_count_q <= word_count_q + 1'b1;
            // An end beat in the last slot is a legal full program, not overflow.
            if (w_end_beat) begin
              state_q    <= S_INIT;
              cpu_init_q <= 1'b1;
            end else if (ptr_q == C_LAST_PTR) begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        S_INIT: begin
          cycle_count_q <= '0;
          cpu_run_q     <= 1'b1;
          state_q       <= S_RUN;
        end
        S_RUN: begin
          // Halt outranks the watchdog and its cycle is included in the count.
          if (cpu_halted) begin
            state_q       <= S_DONE;
            done_q        <= 1'b1;
            cpu_run_q     <= 1'b0;
            cycle_count_q <= cycle_count_q + 32'd1;
          end else if (cycle_count_q >= C_WD_LIMIT) begin
            state_q   <= S_TIMEOUT;
            timeout_q <= 1'b1;
            cpu_run_q <= 1'b0;
          end else begin
            cycle_count_q <= cycle_count_q + 32'd1;
          end
        end
        S_DONE, S_ERR, S_TIMEOUT: begin
          if (start) begin
            state_q       <= S_LOAD;
            ptr_q         <= '0;
            word_count_q  <= '0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            timeout_q     <= 1'b0;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign cpu_init    = cpu_init_q;
  assign cpu_run     = cpu_run_q;
  assign done        = done_q;
  assign error       = error_q;
  assign timeout     = timeout_q;
  assign word_count  = word_count_q;
  assign cycle_count = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips32_prog_loader.sv
`default_nettype none
// ============================================================================
// tb_mips32_prog_loader : directed plus randomized load/run scenarios
// Revision 1.0
// ============================================================================
module tb_mips32_prog_loader;

  localparam int          ADDR_W     = 4;
  localparam int          DEPTH      = 12;
  localparam int          MAX_CYCLES = 16;
  localparam logic [31:0] HLT        = 32'hfc000000;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              in_last;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_init;
  logic              cpu_run;
  logic              cpu_halted;
  logic              start;
  logic              done;
  logic              error;
  logic              timeout;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       cycle_count;

  always #5 clk = ~clk;

  mips32_prog_loader #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .MAX_CYCLES(MAX_CYCLES), .HLT_WORD(HLT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_init(cpu_init), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .start(start), .done(done), .error(error), .timeout(timeout),
    .word_count(word_count), .cycle_count(cycle_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          init_pulses  = 0;
  int          init_overlap = 0;
  logic [31:0] prog_w[$];
  bit          prog_l[$];

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
    if (cpu_init === 1'b1) init_pulses++;
    if (cpu_init === 1'b1 && cpu_run === 1'b1) init_overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: a program ends at the first last/HLT beat or overflows at DEPTH words.
  function automatic void ref_load(output int n, output bit err);
    n   = 0;
    err = 1'b0;
    for (int i = 0; i < prog_w.size(); i++) begin
      n = i + 1;
      if (prog_l[i] || prog_w[i] == HLT) return;
      if (n == DEPTH) begin
        err = 1'b1;
        return;
      end
    end
  endfunction

  task automatic feed(input int mode);
    int idx = 0;
    int cyc = 0;
    while (idx < prog_w.size() && cyc < 400) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = prog_w[idx];
      in_last = prog_l[idx];
      cyc++;
      if (in_valid && in_ready) begin
        step();
        idx++;
        if (!in_ready) break;
      end else begin
        step();
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    chk("feed_bound", 32'(cyc < 400), 32'd1);
  endtask

  task automatic run_program(input string name, input int mode, input int h);
    int n;
    bit err;
    int run_cyc = 0;
    int wait_c  = 0;
    int k;
    wr_addr.delete();
    wr_data.delete();
    init_pulses = 0;
    cpu_halted  = 1'b0;
    ref_load(n, err);
    feed(mode);
    while (!cpu_run && !error && wait_c < 8) begin
      step();
      wait_c++;
    end
    while (cpu_run && run_cyc < 4 * MAX_CYCLES) begin
      cpu_halted = (run_cyc >= h);
      run_cyc++;
      step();
    end
    cpu_halted = 1'b0;
    step();
    step();
    k = h + 1;
    chk({name, " word_count"}, 32'(word_count), n);
    chk({name, " writes"}, wr_addr.size(), n);
    for (int i = 0; i < n && i < wr_addr.size(); i++) begin
      chk({name, " addr"}, wr_addr[i], i);
      chk({name, " data"}, wr_data[i], prog_w[i]);
    end
    chk({name, " error"}, error, err);
    chk({name, " init_pulses"}, init_pulses, err ? 0 : 1);
    if (err) begin
      chk({name, " done"}, done, 0);
      chk({name, " run_cycles"}, run_cyc, 0);
    end else if (k <= MAX_CYCLES) begin
      chk({name, " done"}, done, 1);
      chk({name, " timeout"}, timeout, 0);
      chk({name, " cycle_count"}, cycle_count, k);
      chk({name, " run_cycles"}, run_cyc, k);
    end else begin
      chk({name, " done"}, done, 0);
      chk({name, " timeout"}, timeout, 1);
      chk({name, " cycle_count"}, cycle_count, MAX_CYCLES - 1);
      chk({name, " run_cycles"}, run_cyc, MAX_CYCLES);
    end
    chk({name, " cpu_run"}, cpu_run, 0);
    chk({name, " in_ready"}, in_ready, 0);
  endtask

  task automatic restart();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart flags", {done, error, timeout}, 3'b000);
    chk("restart word_count", 32'(word_count), 0);
    chk("restart cycle_count", cycle_count, 0);
    chk("restart in_ready", in_ready, 1);
  endtask

  task automatic set_prog(input logic [31:0] w[], input bit l[]);
    prog_w.delete();
    prog_l.delete();
    for (int i = 0; i < w.size(); i++) begin
      prog_w.push_back(w[i]);
      prog_l.push_back(l[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [31:0] demo_w[] = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800,
                              32'h0ce77800, 32'h00222000, 32'h0ce77800, 32'h00832800,
                              32'hfc000000};
    bit          demo_l[] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] w;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    cpu_halted = 1'b0; start = 1'b0;
    step(); step(); step();
    chk("reset in_ready", in_ready, 1);
    chk("reset mem_we", mem_we, 0);
    chk("reset cpu_init", cpu_init, 0);
    chk("reset cpu_run", cpu_run, 0);
    chk("reset flags", {done, error, timeout}, 3'b000);
    chk("reset word_count", 32'(word_count), 0);
    chk("reset cycle_count", cycle_count, 0);
    reset = 1'b0;
    step();

    set_prog(demo_w, demo_l);
    run_program("demo_stream", 0, int'($urandom_range(0, 10)));

    restart();
    run_program("demo_gapped", 1, int'($urandom_range(0, 10)));

    restart();
    prog_w.delete();
    prog_l.delete();
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = $urandom;
      if (w == HLT) w = w ^ 32'h1;
      prog_w.push_back(w);
      prog_l.push_back(1'b0);
    end
    run_program("overflow", 0, 0);

    restart();
    set_prog('{32'h0ce77800, 32'h0ce77800}, '{0, 1});
    run_program("watchdog", 0, 1000);

    restart();
    set_prog('{32'h28010005, 32'hfc000000}, '{0, 0});
    run_program("halt_at_limit", 0, MAX_CYCLES - 1);

    for (int it = 0; it < 8; it++) begin
      int len;
      restart();
      prog_w.delete();
      prog_l.delete();
      len = int'($urandom_range(1, 15));
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        if ($urandom_range(0, 5) == 0) w = HLT;
        prog_w.push_back(w);
        prog_l.push_back($urandom_range(0, 7) == 0);
      end
      if (len < DEPTH) prog_l[len-1] = 1'b1;
      run_program("random", 2, int'($urandom_range(0, 20)));
    end

    restart();
    set_prog('{32'h28010005, 32'h28020007, 32'h00221800}, '{0, 0, 1});
    cpu_halted = 1'b0;
    feed(0);
    for (int i = 0; i < 5; i++) step();
    chk("midrun cpu_run_before", cpu_run, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrun cpu_run", cpu_run, 0);
    chk("midrun in_ready", in_ready, 1);
    chk("midrun word_count", 32'(word_count), 0);
    chk("midrun cycle_count", cycle_count, 0);
    chk("midrun flags", {done, error, timeout}, 3'b000);
    chk("midrun mem_we", mem_we, 0);

    chk("init_run_overlap", init_overlap, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
Program-load and run-control stage that sits directly upstream of pipe_MIPS32. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the processor's instruction memory from address 0. It then initialises the processor control state (PC, HALTED, TAKEN_BRANCH), releases the processor, and supervises execution with a cycle counter and watchdog until HLT retires.

Parameters:
ADDR_W, 10, instruction memory address width in words
DEPTH, 1024, number of writable memory words (must be <= 2**ADDR_W)
MAX_CYCLES, 4096, watchdog limit on run cycles before timeout
HLT_WORD, 32'hfc000000, opcode word treated as implicit end of program

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream instruction word valid
in_ready  output  1  loader can accept a word this cycle
in_data  input  32  instruction word
in_last  input  1  marks final word of the program
mem_we  output  1  instruction memory write enable
mem_addr  output  ADDR_W  instruction memory write address
mem_wdata  output  32  instruction memory write data
cpu_init  output  1  one-cycle pulse: processor sets PC=0, HALTED=0, TAKEN_BRANCH=0
cpu_run  output  1  processor enable; processor holds state while low
cpu_halted  input  1  processor HALTED flag
start  input  1  restart request, honoured only in DONE/ERR/TIMEOUT
done  output  1  program completed normally
error  output  1  program overflowed DEPTH
timeout  output  1  watchdog expired
word_count  output  ADDR_W+1  number of words loaded
cycle_count  output  32  clk cycles spent in RUN

Behaviour:
- Reset, checked every edge with priority over all else: state=LOAD, ptr=0, word_count=0, cycle_count=0. Outputs in_ready=1, mem_we=0, cpu_init=0, cpu_run=0, done=error=timeout=0. Reset mid-RUN drops cpu_run on the next edge.
- States: LOAD, INIT, RUN, DONE, ERR, TIMEOUT.
- LOAD: in_ready=1. A beat is accepted when in_valid&&in_ready. On acceptance, mem_we=1, mem_addr=ptr and mem_wdata=in_data are registered, so the write appears one cycle after acceptance. ptr and word_count then increment.
- End of program: an accepted beat with in_last=1 or in_data==HLT_WORD → INIT. That word is still written. Beats after the end are not accepted because in_ready=0 outside LOAD.
- Overflow: an accepted beat at ptr==DEPTH-1 that is not an end-of-program beat is written, then state → ERR. error=1 and in_ready=0.
- Empty program: none. The first end-of-program beat counts as word 0.
- INIT: exactly one cycle. cpu_init=1 and cpu_run=0. cycle_count is cleared. Next state is RUN.
- RUN: cpu_run=1 and cycle_count increments every cycle. If cpu_halted=1 is sampled, state → DONE with done=1 and cpu_run=0 on that edge; the final cycle_count includes that cycle. If cycle_count reaches MAX_CYCLES-1 without halt, state → TIMEOUT with timeout=1 and cpu_run=0. If halt and the watchdog limit occur on the same edge, DONE wins.
- cpu_halted is ignored outside RUN.
- DONE, ERR and TIMEOUT are sticky. Status flags, word_count and cycle_count hold their values.
- A start=1 pulse in DONE, ERR or TIMEOUT returns the block to LOAD and clears ptr, word_count, the status flags and cycle_count. start is ignored in LOAD, INIT and RUN.
- mem_addr wraps never; ptr is bounded by DEPTH. word_count is ADDR_W+1 bits so it can represent DEPTH.
- All outputs are registered. There are no combinational paths from inputs to outputs except in_ready, which is a pure function of state.

Test Plan:
- Load 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000 with in_valid held high → 9 writes at addresses 0..8 with matching data, word_count=9, one cpu_init pulse followed by cpu_run=1. With pipe_MIPS32 attached: done=1, R1=10, R2=20, R3=25, R4=30, R5=55.
- Toggle in_valid as 1,0,0,1 per word while loading the same program → identical memory contents and no duplicate or skipped addresses.
- Set DEPTH=4 and stream 5 words with no last or HLT → 4 writes, error=1, in_ready=0, cpu_init never asserted.
- Stream a program of 0ce77800 ×2 with in_last on the second word, and tie cpu_halted=0 with MAX_CYCLES=16 → timeout=1 after 16 RUN cycles, cycle_count=15, cpu_run=0.
- After DONE, pulse start and load 28010005, fc000000 → flags cleared, word_count=2, done=1 again.
- Assert reset for one cycle mid-RUN → next cycle state is LOAD, cpu_run=0, in_ready=1, all counters 0.
